// File: rtl/mux16_scanner_if.sv
// Bus between the mux16 scanner and its mux/consumer: select, mux output, snapshot handshake.
// Optional CHANGE_MASK_EN adds the change_mask signal.
interface mux16_scanner_if;
    // Handshake: valid stays high with snapshot stable until a clock edge with
    // valid && ready; that edge completes the transfer. ready without valid is ignored.
    logic        start;
    logic        f;
    logic [3:0]  sel;
    logic        busy;
    logic [15:0] snapshot;
    logic        valid;
    logic        ready;
`ifdef CHANGE_MASK_EN
    logic [15:0] change_mask;
`endif

    modport master (
        input  start,
        input  f,
        input  ready,
        output sel,
        output busy,
        output snapshot,
        output valid
`ifdef CHANGE_MASK_EN
        , output change_mask
`endif
    );

    modport slave (
        output start,
        output f,
        output ready,
        input  sel,
        input  busy,
        input  snapshot,
        input  valid
`ifdef CHANGE_MASK_EN
        , input change_mask
`endif
    );
endinterface

// File: rtl/mux16_scanner.sv
// Walks a 16:1 mux select, samples f after a settle interval per channel and publishes
// the assembled word with valid/ready. Optional CHANGE_MASK_EN adds a per-pass change mask.
module mux16_scanner #(
    parameter int NUM_CH     = 16,
    parameter int SETTLE_CYC = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    mux16_scanner_if.master   bus,
    output logic [1:0]        dbg_state_o
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        HOLD   = 2'd2
    } state_e;

    localparam logic [3:0] SETTLE_INIT = 4'(SETTLE_CYC);
    localparam logic [3:0] LAST_SEL    = 4'(NUM_CH - 1);

    state_e      state_q, state_d;
    logic [3:0]  sel_q, sel_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [15:0] shadow_q, shadow_d;
    logic [15:0] snapshot_q, snapshot_d;
    logic        valid_q, valid_d;
`ifdef CHANGE_MASK_EN
    logic [15:0] change_mask_q, change_mask_d;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            sel_q         <= 4'd0;
            cnt_q         <= 4'd0;
            shadow_q      <= 16'd0;
            snapshot_q    <= 16'd0;
            valid_q       <= 1'b0;
`ifdef CHANGE_MASK_EN
            change_mask_q <= 16'd0;
`endif
        end else begin
            state_q       <= state_d;
            sel_q         <= sel_d;
            cnt_q         <= cnt_d;
            shadow_q      <= shadow_d;
            snapshot_q    <= snapshot_d;
            valid_q       <= valid_d;
`ifdef CHANGE_MASK_EN
            change_mask_q <= change_mask_d;
`endif
        end
    end

    always_comb begin
        state_d       = state_q;
        sel_d         = sel_q;
        cnt_d         = cnt_q;
        shadow_d      = shadow_q;
        snapshot_d    = snapshot_q;
        valid_d       = valid_q;
`ifdef CHANGE_MASK_EN
        change_mask_d = change_mask_q;
`endif
        case (state_q)
            IDLE: begin
                valid_d = 1'b0;
                sel_d   = 4'd0;
                if (bus.start) begin
                    shadow_d = 16'd0;
                    cnt_d    = SETTLE_INIT;
                    state_d  = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    shadow_d[sel_q] = bus.f;
                    if (sel_q == LAST_SEL) begin
                        // Only the completed word is ever published, never the shadow.
                        snapshot_d = shadow_d;
`ifdef CHANGE_MASK_EN
                        change_mask_d = shadow_d ^ snapshot_q;
`endif
                        valid_d = 1'b1;
                        sel_d   = 4'd0;
                        state_d = HOLD;
                    end else begin
                        sel_d = sel_q + 4'd1;
                        cnt_d = SETTLE_INIT;
                    end
                end
            end
            HOLD: begin
                if (valid_q && bus.ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                valid_d = 1'b0;
                sel_d   = 4'd0;
            end
        endcase
    end

    assign bus.sel      = sel_q;
    assign bus.busy     = (state_q != IDLE);
    assign bus.snapshot = snapshot_q;
    assign bus.valid    = valid_q;
`ifdef CHANGE_MASK_EN
    assign bus.change_mask = change_mask_q;
`endif
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_mux16_scanner.sv
// Directed bench for mux16_scanner: default, SETTLE_CYC=0 and NUM_CH=8 instances,
// table-driven scans plus backpressure and reset corner sequences.
module tb_mux16_scanner;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mux16_scanner_if if_a ();
    mux16_scanner_if if_b ();
    mux16_scanner_if if_c ();

    logic [1:0] dbg_a, dbg_b, dbg_c;

    mux16_scanner #(.NUM_CH(16), .SETTLE_CYC(1)) u_a (
        .clk(clk), .rst_n(rst_n), .bus(if_a.master), .dbg_state_o(dbg_a));
    mux16_scanner #(.NUM_CH(16), .SETTLE_CYC(0)) u_b (
        .clk(clk), .rst_n(rst_n), .bus(if_b.master), .dbg_state_o(dbg_b));
    mux16_scanner #(.NUM_CH(8), .SETTLE_CYC(1)) u_c (
        .clk(clk), .rst_n(rst_n), .bus(if_c.master), .dbg_state_o(dbg_c));

    // External mux patterns feeding f from the driven select
    logic [15:0] pat_a = 16'h0, pat_b = 16'h0, pat_c = 16'h0;
    logic [2:0]  start_v = 3'b000;
    logic [2:0]  ready_v = 3'b000;

    assign if_a.f = pat_a[if_a.sel];
    assign if_b.f = pat_b[if_b.sel];
    assign if_c.f = pat_c[if_c.sel];
    assign if_a.start = start_v[0];
    assign if_b.start = start_v[1];
    assign if_c.start = start_v[2];
    assign if_a.ready = ready_v[0];
    assign if_b.ready = ready_v[1];
    assign if_c.ready = ready_v[2];

    logic [3:0]  sel_o   [3];
    logic [15:0] snap_o  [3];
    logic        valid_o [3];
    logic        busy_o  [3];
    assign sel_o[0] = if_a.sel;       assign sel_o[1] = if_b.sel;       assign sel_o[2] = if_c.sel;
    assign snap_o[0] = if_a.snapshot; assign snap_o[1] = if_b.snapshot; assign snap_o[2] = if_c.snapshot;
    assign valid_o[0] = if_a.valid;   assign valid_o[1] = if_b.valid;   assign valid_o[2] = if_c.valid;
    assign busy_o[0] = if_a.busy;     assign busy_o[1] = if_b.busy;     assign busy_o[2] = if_c.busy;

`ifdef CHANGE_MASK_EN
    logic [15:0] mask_a;
    assign mask_a = if_a.change_mask;
`endif

    int n_checks = 0;
    int n_fail   = 0;
    logic [15:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Pulse start, follow sel cycle by cycle, then compare latency and snapshot.
    task automatic run_scan(input int which, input logic [15:0] exp_snap, input logic [15:0] exp_mask,
                            input int settle, input int nch);
        int k;
        logic [15:0] exp;
        exp_q.push_back(exp_snap);
        @(negedge clk);
        start_v[which] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[which] = 1'b0;
        check("busy_after_start", 32'(busy_o[which]), 32'd1);
        k = 0;
        while (!valid_o[which] && k < 300) begin
            check("sel_order", 32'(sel_o[which]), 32'(k / (settle + 1)));
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(nch * (settle + 1)));
        exp = exp_q.pop_front();
        check("snapshot", 32'(snap_o[which]), 32'(exp));
        check("sel_in_hold", 32'(sel_o[which]), 32'd0);
`ifdef CHANGE_MASK_EN
        if (which == 0) check("change_mask", 32'(mask_a), 32'(exp_mask));
`else
        if (exp_mask != exp_mask) check("mask_unused", 32'd0, 32'd1);
`endif
    endtask

    task automatic accept(input int which);
        @(negedge clk);
        ready_v[which] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ready_v[which] = 1'b0;
        check("valid_after_accept", 32'(valid_o[which]), 32'd0);
        check("busy_after_accept", 32'(busy_o[which]), 32'd0);
    endtask

    typedef struct {
        logic [15:0] pat;
        logic [15:0] snap;
        logic [15:0] mask;
    } vec_t;
    vec_t vecs[4];

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [15:0] held;
        vecs[0] = '{pat: 16'hA5C3, snap: 16'hA5C3, mask: 16'hA5C3};
        vecs[1] = '{pat: 16'hFFFF, snap: 16'hFFFF, mask: 16'h5A3C};
        vecs[2] = '{pat: 16'h0000, snap: 16'h0000, mask: 16'hFFFF};
        vecs[3] = '{pat: 16'h1234, snap: 16'h1234, mask: 16'h1234};

        // Reset then idle, with ready toggled to show it has no effect
        do_reset();
        for (int c = 0; c < 10; c++) begin
            ready_v = (c >= 5) ? 3'b111 : 3'b000;
            @(posedge clk);
            @(negedge clk);
            check("idle_sel", 32'(if_a.sel), 32'd0);
            check("idle_busy", 32'(if_a.busy), 32'd0);
            check("idle_valid", 32'(if_a.valid), 32'd0);
            check("idle_snapshot", 32'(if_a.snapshot), 32'd0);
            check("idle_busy_b", 32'(if_b.busy), 32'd0);
            check("idle_valid_c", 32'(if_c.valid), 32'd0);
        end
        ready_v = 3'b000;

        for (int i = 0; i < 4; i++) begin
            pat_a = vecs[i].pat;
            run_scan(0, vecs[i].snap, vecs[i].mask, 1, 16);
            accept(0);
        end

        // Backpressure with start pulsed during HOLD
        pat_a = 16'hC3C3;
        run_scan(0, 16'hC3C3, 16'hD1F7, 1, 16);
        for (int c = 0; c < 5; c++) begin
            start_v[0] = (c == 2);
            @(posedge clk);
            @(negedge clk);
            check("hold_valid", 32'(if_a.valid), 32'd1);
            check("hold_snapshot", 32'(if_a.snapshot), 32'hC3C3);
        end
        start_v[0] = 1'b0;
        accept(0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk);
            @(negedge clk);
            check("no_second_scan", 32'(if_a.busy), 32'd0);
        end

        // Reset mid-scan: no partial word may appear
        pat_a = 16'hFFFF;
        @(negedge clk);
        start_v[0] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start_v[0] = 1'b0;
        repeat (8) begin
            @(posedge clk);
            @(negedge clk);
        end
        held = if_a.snapshot;
        check("snapshot_stable_mid_scan", 32'(held), 32'hC3C3);
        rst_n = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check("rst_mid_sel", 32'(if_a.sel), 32'd0);
        check("rst_mid_valid", 32'(if_a.valid), 32'd0);
        check("rst_mid_busy", 32'(if_a.busy), 32'd0);
        check("rst_mid_snapshot", 32'(if_a.snapshot), 32'd0);
`ifdef CHANGE_MASK_EN
        check("rst_mid_mask", 32'(mask_a), 32'd0);
`endif
        pat_a = 16'h1234;
        run_scan(0, 16'h1234, 16'h1234, 1, 16);
        accept(0);

        // Change mask sequence from a fresh reset
        do_reset();
        pat_a = 16'h00FF;
        run_scan(0, 16'h00FF, 16'h00FF, 1, 16);
        accept(0);
        pat_a = 16'h0F0F;
        run_scan(0, 16'h0F0F, 16'h0FF0, 1, 16);
        accept(0);
        check("snapshot_kept_idle", 32'(if_a.snapshot), 32'h0F0F);

        // SETTLE_CYC=0 instance
        pat_b = 16'h8001;
        run_scan(1, 16'h8001, 16'h0000, 0, 16);
        accept(1);

        // NUM_CH=8 instance: upper bits stay zero
        pat_c = 16'hFFFF;
        run_scan(2, 16'h00FF, 16'h0000, 1, 8);
        accept(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
